// File: rtl/countdown_timer.sv
// Microwave cook-time keeper: three BCD digits (M:ST), keypad entry,
// once-per-second countdown while cooking, door interlock, end-of-cook pulse.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] sec_unidades,
  output logic [3:0] sec_dezenas,
  output logic [3:0] minutos,
  output logic       magnetron_on,
  output logic       done
);

  // state | meaning
  // IDLE  | time entry via keypad, magnetron off
  // COOK  | counting down, magnetron on
  // PAUSE | stopped or door opened mid-cook, digits and prescaler frozen
  typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    uni_nxt, dez_nxt, min_nxt;
  logic          done_nxt;

  logic [3:0]    dec_u, dec_d, dec_m;
  logic          dec_zero, time_zero, halt;

  assign time_zero = (minutos == 4'd0) && (sec_dezenas == 4'd0) && (sec_unidades == 4'd0);
  assign halt      = stop || !door_closed;

  // One-second decrement with borrow; tens above 5 count down like any other digit.
  always_comb begin
    dec_u = sec_unidades;
    dec_d = sec_dezenas;
    dec_m = minutos;
    if (sec_unidades != 4'd0) begin
      dec_u = sec_unidades - 4'd1;
    end else if (sec_dezenas != 4'd0) begin
      dec_d = sec_dezenas - 4'd1;
      dec_u = 4'd9;
    end else if (minutos != 4'd0) begin
      dec_m = minutos - 4'd1;
      dec_d = 4'd5;
      dec_u = 4'd9;
    end
    dec_zero = (dec_m == 4'd0) && (dec_d == 4'd0) && (dec_u == 4'd0);
  end

  // Next-state and next-register values; priority clear > stop/door > start > digit.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    uni_nxt   = sec_unidades;
    dez_nxt   = sec_dezenas;
    min_nxt   = minutos;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          uni_nxt = 4'd0;
          dez_nxt = 4'd0;
          min_nxt = 4'd0;
        end else if (halt) begin
          // door open or stop asserted: nothing to do while idle
        end else if (start) begin
          if (!time_zero) begin
            state_nxt = COOK;
            presc_nxt = '0;
          end
        end else if (digit_valid && (digit <= 4'd9)) begin
          min_nxt = sec_dezenas;
          dez_nxt = sec_unidades;
          uni_nxt = digit;
        end
      end
      COOK: begin
        if (clear) begin
          state_nxt = IDLE;
          uni_nxt   = 4'd0;
          dez_nxt   = 4'd0;
          min_nxt   = 4'd0;
        end else if (halt) begin
          state_nxt = PAUSE;
        end else if (presc != PRESC_LAST) begin
          presc_nxt = presc + 1'b1;
        end else begin
          presc_nxt = '0;
          uni_nxt   = dec_u;
          dez_nxt   = dec_d;
          min_nxt   = dec_m;
          if (dec_zero) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (clear || stop) begin
          state_nxt = IDLE;
          uni_nxt   = 4'd0;
          dez_nxt   = 4'd0;
          min_nxt   = 4'd0;
        end else if (start && door_closed) begin
          state_nxt = COOK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, prescaler and all outputs registered; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      sec_unidades <= 4'd0;
      sec_dezenas  <= 4'd0;
      minutos      <= 4'd0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      sec_unidades <= uni_nxt;
      sec_dezenas  <= dez_nxt;
      minutos      <= min_nxt;
      magnetron_on <= (state_nxt == COOK);
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4: expected display
// and flags are queued when a step is driven and compared after its edge.
module tb_countdown_timer;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset, digit_valid, start, stop, clear, door_closed;
  logic [3:0] digit;
  logic [3:0] sec_unidades, sec_dezenas, minutos;
  logic       magnetron_on, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] m, d, u;
    logic       mag, dn;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .sec_unidades(sec_unidades), .sec_dezenas(sec_dezenas), .minutos(minutos),
    .magnetron_on(magnetron_on), .done(done)
  );

  task automatic push(input string tag, input logic [3:0] m, input logic [3:0] d,
                      input logic [3:0] u, input logic mag, input logic dn);
    exp_t e;
    e.tag = tag; e.m = m; e.d = d; e.u = u; e.mag = mag; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty: no expected entry queued at t=%0t", $time);
      return;
    end
    e = sb.pop_front();
    assert ({minutos, sec_dezenas, sec_unidades, magnetron_on, done} ===
            {e.m, e.d, e.u, e.mag, e.dn})
    else begin
      failures++;
      $error("FAIL %s: got %0d:%0d%0d mag=%0b done=%0b, expected %0d:%0d%0d mag=%0b done=%0b",
             e.tag, minutos, sec_dezenas, sec_unidades, magnetron_on, done,
             e.m, e.d, e.u, e.mag, e.dn);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input logic [3:0] v);
    digit_valid = 1'b1;
    digit       = v;
    tick();
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; digit_valid = 1'b0; digit = 4'd0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; door_closed = 1'b1;

    // reset values
    #23;
    push("reset_state", 0, 0, 0, 0, 0); check_out();
    reset = 1'b0;
    tick();

    // keypad entry, invalid key ignored
    push("key_1", 0, 0, 1, 0, 0);  key(4'd1);  check_out();
    push("key_3", 0, 1, 3, 0, 0);  key(4'd3);  check_out();
    push("key_0", 1, 3, 0, 0, 0);  key(4'd0);  check_out();
    push("key_12", 1, 3, 0, 0, 0); key(4'd12); check_out();

    // 0:02 full countdown with done pulse
    push("clear_idle", 0, 0, 0, 0, 0); do_clear(); check_out();
    key(4'd2);
    push("start_02", 0, 0, 2, 1, 0); do_start(); check_out();
    push("pre_tick1", 0, 0, 2, 1, 0); ticks(T - 1); check_out();
    push("tick1_01", 0, 0, 1, 1, 0);  tick(); check_out();
    ticks(T - 1);
    push("expire_done", 0, 0, 0, 0, 1); tick(); check_out();
    push("done_low", 0, 0, 0, 0, 0);    tick(); check_out();

    // borrow 1:00 -> 0:59
    key(4'd1); key(4'd0); key(4'd0);
    push("start_100", 1, 0, 0, 1, 0); do_start(); check_out();
    push("borrow_059", 0, 5, 9, 1, 0); ticks(T); check_out();
    do_clear();

    // borrow 0:10 -> 0:09
    key(4'd1); key(4'd0);
    do_start();
    push("borrow_009", 0, 0, 9, 1, 0); ticks(T); check_out();
    do_clear();

    // 0:75 counts as 74, then 70 -> 69
    key(4'd7); key(4'd5);
    do_start();
    push("dec_074", 0, 7, 4, 1, 0); ticks(T); check_out();
    push("dec_069", 0, 6, 9, 1, 0); ticks(5 * T); check_out();
    do_clear();

    // pause on door open with prescaler at 2, resume fires on 2nd cook cycle
    key(4'd5);
    do_start();
    ticks(2);
    door_closed = 1'b0;
    push("door_pause", 0, 0, 5, 0, 0); tick(); check_out();
    for (int i = 0; i < 20; i++) begin
      start = (i >= 5 && i < 10);
      push("pause_frozen", 0, 0, 5, 0, 0); tick(); check_out();
    end
    start = 1'b0;
    door_closed = 1'b1;
    push("door_closed_wait", 0, 0, 5, 0, 0); tick(); check_out();
    push("resume", 0, 0, 5, 1, 0);    do_start(); check_out();
    push("resume_c1", 0, 0, 5, 1, 0); tick(); check_out();
    push("resume_c2", 0, 0, 4, 1, 0); tick(); check_out();

    // stop during pause returns to idle zeroed
    stop = 1'b1; tick();
    push("stop_pause_idle", 0, 0, 0, 0, 0); tick(); check_out();
    stop = 1'b0;

    // start ignored at 0:00 and with door open
    push("start_zero", 0, 0, 0, 0, 0); do_start(); check_out();
    key(4'd3);
    door_closed = 1'b0;
    push("start_door_open", 0, 0, 3, 0, 0); do_start(); check_out();
    door_closed = 1'b1;
    do_clear();

    // clear during cook at 0:30
    key(4'd3); key(4'd0);
    do_start();
    ticks(2);
    push("clear_cook", 0, 0, 0, 0, 0); do_clear(); check_out();
    push("clear_no_done", 0, 0, 0, 0, 0); tick(); check_out();

    // asynchronous reset mid-cook
    key(4'd9);
    do_start();
    tick();
    #2;
    reset = 1'b1;
    #1;
    push("async_reset", 0, 0, 0, 0, 0); check_out();
    #1;
    reset = 1'b0;
    push("post_reset_key5", 0, 0, 5, 0, 0); key(4'd5); check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
